// File: rtl/vga_scanout_if.sv
// Framebuffer read port between the scanout engine and the framebuffer RAM.
// The scanout side issues one-clock read strobes; data returns one clock later.
interface vga_scanout_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 15
);
    logic                    fb_rd_en;
    logic [ADDR_WIDTH-1:0]   fb_rd_addr;
    logic [WIDTH*12-1:0]     fb_rd_data;

    modport master (
        output fb_rd_en,
        output fb_rd_addr,
        input  fb_rd_data
    );

    modport slave (
        input  fb_rd_en,
        input  fb_rd_addr,
        output fb_rd_data
    );
endinterface

// File: rtl/vga_scanout.sv
// VGA scanout: pixel-enable raster timing, one-word-ahead framebuffer prefetch,
// and serialisation of packed 12-bit pixels onto registered RGB/sync outputs.
module vga_scanout #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 15,
    parameter int PIX_DIV    = 4,
    parameter int H_ACT      = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACT      = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33
) (
    input  logic                clock,
    input  logic                reset,
    vga_scanout_if.master       fb,
    output logic                hSync,
    output logic                vSync,
    output logic [3:0]          VGA_R,
    output logic [3:0]          VGA_G,
    output logic [3:0]          VGA_B,
    output logic                frame_start
);
    localparam int H_TOTAL  = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACT + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACT + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int DW       = $clog2(PIX_DIV);
    localparam int LW       = $clog2(WIDTH);
    localparam int WORDS    = H_ACT / WIDTH;
    localparam int PW       = WIDTH * 12;

    logic [DW-1:0]         div;
    logic                  pix_en;
    logic [HW-1:0]         h;
    logic [VW-1:0]         v;
    logic [ADDR_WIDTH-1:0] line_base;
    logic                  rd_pend;
    logic [PW-1:0]         hold;
    logic [PW-1:0]         shift;

    logic                  h_last;
    logic                  v_last;
    logic                  active;
    logic                  pix_first;
    logic                  pix_last;
    logic                  rd_mid;
    logic                  rd_line;
    logic                  next_vis;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [PW-1:0]         load_word;

    assign pix_en    = (div == DW'(PIX_DIV - 1));
    assign h_last    = (h == HW'(H_TOTAL - 1));
    assign v_last    = (v == VW'(V_TOTAL - 1));
    assign active    = (h < HW'(H_ACT)) && (v < VW'(V_ACT));
    assign pix_first = (h[LW-1:0] == '0);
    assign pix_last  = &h[LW-1:0];

    // Mid-line prefetch fetches the word following the one being displayed.
    assign rd_mid   = pix_last && (h < HW'(H_ACT - 1)) && (v < VW'(V_ACT));
    // End-of-line prefetch fetches word 0 of the next line if it is visible.
    assign next_vis = v_last || (v < VW'(V_ACT - 1));
    assign rd_line  = h_last && next_vis;
    assign word_idx = ADDR_WIDTH'(h[HW-1:LW]) + ADDR_WIDTH'(1);

    // With a two-clock pixel period the capture and load land on one edge,
    // so the load takes the returning RAM data directly.
    assign load_word = rd_pend ? fb.fb_rd_data : hold;

    // Pixel-enable divider: pix_en on the last clock of each pixel period.
    always_ff @(posedge clock) begin
        if (reset) begin
            div <= '0;
        end else if (pix_en) begin
            div <= '0;
        end else begin
            div <= div + DW'(1);
        end
    end

    // Raster counters advance one pixel per pix_en.
    always_ff @(posedge clock) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                h <= '0;
                if (v_last) begin
                    v <= '0;
                end else begin
                    v <= v + VW'(1);
                end
            end else begin
                h <= h + HW'(1);
            end
        end
    end

    // Line base address tracks v*WORDS for visible lines without a multiplier.
    always_ff @(posedge clock) begin
        if (reset) begin
            line_base <= '0;
        end else if (pix_en && h_last) begin
            if (v_last) begin
                line_base <= '0;
            end else if (v < VW'(V_ACT - 1)) begin
                line_base <= line_base + ADDR_WIDTH'(WORDS);
            end
        end
    end

    // Framebuffer read strobe and address, one pulse per prefetch.
    always_ff @(posedge clock) begin
        if (reset) begin
            fb.fb_rd_en   <= 1'b0;
            fb.fb_rd_addr <= '0;
        end else begin
            fb.fb_rd_en <= pix_en && (rd_mid || rd_line);
            if (pix_en && rd_mid) begin
                fb.fb_rd_addr <= line_base + word_idx;
            end else if (pix_en && rd_line) begin
                if (v_last) begin
                    fb.fb_rd_addr <= '0;
                end else begin
                    fb.fb_rd_addr <= line_base + ADDR_WIDTH'(WORDS);
                end
            end
        end
    end

    // Capture returning read data into the hold register.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_pend <= 1'b0;
            hold    <= '0;
        end else begin
            rd_pend <= fb.fb_rd_en;
            if (rd_pend) begin
                hold <= fb.fb_rd_data;
            end
        end
    end

    // Sync and frame-start outputs, one pixel behind the counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            hSync       <= 1'b1;
            vSync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && (h == '0) && (v == '0);
            if (pix_en) begin
                hSync <= !((h >= HW'(HS_START)) && (h < HW'(HS_END)));
                vSync <= !((v >= VW'(VS_START)) && (v < VW'(VS_END)));
            end
        end
    end

    // Pixel serialiser: load a word at each word boundary, shift per pixel,
    // and blank outside the active region.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift <= '0;
            VGA_R <= '0;
            VGA_G <= '0;
            VGA_B <= '0;
        end else if (pix_en) begin
            if (!active) begin
                VGA_R <= '0;
                VGA_G <= '0;
                VGA_B <= '0;
            end else if (pix_first) begin
                shift <= load_word;
                {VGA_R, VGA_G, VGA_B} <= load_word[11:0];
            end else begin
                shift <= shift >> 12;
                {VGA_R, VGA_G, VGA_B} <= shift[12 +: 12];
            end
        end
    end
endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout on a reduced raster.
// Expected outputs are computed from the clock count since reset release.
module tb_vga_scanout;
    localparam int WIDTH   = 4;
    localparam int AW      = 8;
    localparam int PIX_DIV = 3;
    localparam int H_ACT   = 16;
    localparam int H_FP    = 2;
    localparam int H_SYNC  = 3;
    localparam int H_BP    = 3;
    localparam int V_ACT   = 6;
    localparam int V_FP    = 1;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 1;
    localparam int HT      = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int VT      = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int WPL     = H_ACT / WIDTH;
    localparam int FRAME   = HT * VT;
    localparam int PW      = WIDTH * 12;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic hSync;
    logic vSync;
    logic frame_start;
    logic [3:0] VGA_R;
    logic [3:0] VGA_G;
    logic [3:0] VGA_B;

    always #5 clock = ~clock;

    vga_scanout_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) fbi();

    vga_scanout #(
        .WIDTH(WIDTH), .ADDR_WIDTH(AW), .PIX_DIV(PIX_DIV),
        .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .fb(fbi),
        .hSync(hSync),
        .vSync(vSync),
        .VGA_R(VGA_R),
        .VGA_G(VGA_G),
        .VGA_B(VGA_B),
        .frame_start(frame_start)
    );

    logic [PW-1:0] mem [0:255];

    // One-clock-latency framebuffer RAM.
    always @(posedge clock) begin
        if (fbi.fb_rd_en) fbi.fb_rd_data <= mem[fbi.fb_rd_addr];
    end

    // Clocks elapsed since reset was last sampled high.
    int unsigned kk = 0;
    always @(posedge clock) kk <= reset ? 0 : kk + 1;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, kk);
        end
    endtask

    task automatic wait_k(int unsigned t);
        int n = 0;
        while (kk < t && n < 5000) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (kk != t) begin
            errors++;
            $display("FAIL wait_k: got %0d expected %0d", kk, t);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) begin
            mem[i] = PW'({$urandom(), $urandom()});
        end
    endtask

    // Reference model: pixel P = k/PIX_DIV - 1 is the one on the outputs.
    always @(negedge clock) begin : model
        int p, h, v, w;
        bit edge_now, en_e, hs_e, vs_e, fs_e;
        int addr_e;
        logic [11:0] rgb_e;
        logic [PW-1:0] word;
        if (chk_on) begin
            en_e = 0; hs_e = 1; vs_e = 1; fs_e = 0; rgb_e = '0; addr_e = 0;
            if (kk >= PIX_DIV) begin
                p = int'(kk) / PIX_DIV - 1;
                h = p % HT;
                v = (p / HT) % VT;
                edge_now = (kk % PIX_DIV) == 0;
                hs_e = !(h >= H_ACT + H_FP && h < H_ACT + H_FP + H_SYNC);
                vs_e = !(v >= V_ACT + V_FP && v < V_ACT + V_FP + V_SYNC);
                fs_e = edge_now && (p % FRAME == 0);
                if (h < H_ACT && v < V_ACT) begin
                    w = v * WPL + h / WIDTH;
                    word = mem[w];
                    if (v == 0 && h < WIDTH && p < FRAME) rgb_e = '0;
                    else rgb_e = word[12 * (h % WIDTH) +: 12];
                end
                if (edge_now && h % WIDTH == WIDTH - 1 && h < H_ACT - 1 && v < V_ACT) begin
                    en_e = 1;
                    addr_e = v * WPL + (h + 1) / WIDTH;
                end
                if (edge_now && h == HT - 1 && ((v + 1) % VT) < V_ACT) begin
                    en_e = 1;
                    addr_e = ((v + 1) % VT) * WPL;
                end
            end
            check("hsync", hSync, hs_e);
            check("vsync", vSync, vs_e);
            check("frame_start", frame_start, fs_e);
            check("rgb", {VGA_R, VGA_G, VGA_B}, rgb_e);
            check("rd_en", fbi.fb_rd_en, en_e);
            if (en_e) check("rd_addr", fbi.fb_rd_addr, addr_e);
        end
    end

    initial begin
        fill_random();
        mem[0] = 48'h00F_0A0_0A0_F00;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_on = 1'b1;
        check("rst_hsync", hSync, 1);
        check("rst_vsync", vSync, 1);
        check("rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
        check("rst_rd_en", fbi.fb_rd_en, 0);
        check("rst_rd_addr", fbi.fb_rd_addr, 0);
        check("rst_fs", frame_start, 0);
        reset = 1'b0;

        wait_k(3);
        check("lit_fs0", frame_start, 1);
        check("lit_rgb_unfetched", {VGA_R, VGA_G, VGA_B}, 0);
        wait_k(12);
        check("lit_rd_first_en", fbi.fb_rd_en, 1);
        check("lit_rd_first_addr", fbi.fb_rd_addr, 1);
        wait_k(54);
        check("lit_hs_before", hSync, 1);
        wait_k(57);
        check("lit_hs_low", hSync, 0);
        wait_k(63);
        check("lit_hs_last", hSync, 0);
        wait_k(66);
        check("lit_hs_after", hSync, 1);
        wait_k(720);
        check("lit_rd0_en", fbi.fb_rd_en, 1);
        check("lit_rd0_addr", fbi.fb_rd_addr, 0);
        wait_k(723);
        check("lit_fs1", frame_start, 1);
        check("lit_px0", {VGA_R, VGA_G, VGA_B}, 12'hF00);
        wait_k(726);
        check("lit_px1", {VGA_R, VGA_G, VGA_B}, 12'h0A0);
        wait_k(732);
        check("lit_px3", {VGA_R, VGA_G, VGA_B}, 12'h00F);
        wait_k(2200);

        for (int r = 0; r < 3; r++) begin
            reset = 1'b1;
            @(negedge clock);
            check("mid_rst_hsync", hSync, 1);
            check("mid_rst_rd_en", fbi.fb_rd_en, 0);
            check("mid_rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
            fill_random();
            repeat ($urandom_range(0, 2)) @(negedge clock);
            reset = 1'b0;
            repeat ($urandom_range(800, 1500)) @(negedge clock);
        end

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
